ddr_ring_dma: RTL and testbench
===============================

# ddr_ring_dma

Parametrised DMA engine that turns a fixed region of DDR2 into one large ring FIFO between the host pipe-in buffer and the host pipe-out buffer. It sits between the two pipe FIFOs and one MIG/MCB user port, all in the MCB user clock domain. Compared with the fixed single-mode engine, it adds:
- configurable data width, burst length and ring size;
- base-address relocation;
- occupancy tracking;
- round-robin arbitration between write bursts and read bursts.

## Interface
Parameters:
- DATA_W, 32, word width of pipe FIFOs and MCB data port (multiple of 8).
- BURST_LEN, 32, words per MCB command; legal range 1..64; cmd_bl = BURST_LEN-1.
- ADDR_W, 30, MCB byte-address width.
- BASE_ADDR, 0, byte address of ring start; aligned to BURST_LEN*DATA_W/8.
- RING_WORDS, 1024, ring size in words; an integer multiple of BURST_LEN.
- CNT_W, 10, width of pipe FIFO count inputs.
- OB_DEPTH, 1023, usable depth of the outbound FIFO.

Ports:
- clk  in  1  MCB user clock (c3_clk0); all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- calib_done  in  1  MCB calibration complete; engine idles while low.
- writes_en  in  1  enables host→DDR bursts.
- reads_en  in  1  enables DDR→host bursts.
- ib_re  out  1  inbound FIFO read strobe.
- ib_data  in  DATA_W  inbound FIFO data; valid the cycle after ib_re.
- ib_valid  in  1  qualifies ib_data.
- ib_count  in  CNT_W  inbound FIFO read-side count.
- ob_we  out  1  outbound FIFO write strobe.
- ob_data  out  DATA_W  outbound FIFO data.
- ob_count  in  CNT_W  outbound FIFO write-side count.
- cmd_en  out  1  MCB command strobe.
- cmd_instr  out  3  3'b000 write, 3'b001 read.
- cmd_bl  out  6  burst length minus one.
- cmd_byte_addr  out  ADDR_W  MCB byte address.
- cmd_full  in  1  MCB command FIFO full.
- wr_en  out  1  MCB write-data strobe.
- wr_data  out  DATA_W  MCB write data.
- wr_mask  out  DATA_W/8  always 0.
- wr_full  in  1  MCB write FIFO full.
- rd_en  out  1  MCB read-data strobe.
- rd_data  in  DATA_W  MCB read data (first-word fall-through).
- rd_empty  in  1  MCB read FIFO empty.
- occupancy  out  clog2(RING_WORDS+1)  words committed in the ring.
- wr_bursts, rd_bursts  out  32  burst counters (see Configuration).

## Operation
Pointers and occupancy:
- wr_ptr and rd_ptr are word indices in 0..RING_WORDS-1.
- Each pointer advances by BURST_LEN per burst and wraps to 0 at RING_WORDS. A burst never straddles the wrap.
- cmd_byte_addr = BASE_ADDR + ptr*(DATA_W/8), truncated to ADDR_W.
- occupancy increases by BURST_LEN on a write cmd_en and decreases by BURST_LEN on a read cmd_en. The two events are never simultaneous, because one FSM issues all commands.

Eligibility, evaluated in IDLE only:
- W_OK = writes_en & ib_count ≥ BURST_LEN & occupancy ≤ RING_WORDS-BURST_LEN.
- R_OK = reads_en & occupancy ≥ BURST_LEN & ob_count ≤ OB_DEPTH-BURST_LEN-1.
- Nothing is eligible while calib_done is low.

Arbitration:
- If only one of W_OK/R_OK is true, that burst is served.
- If both are true, the direction not served last wins; the first tie after reset goes to write.

FSM states:
- IDLE → WR_FILL on a write grant; IDLE → RD_CMD on a read grant.
- WR_FILL:
  - assert ib_re while requested < BURST_LEN and !wr_full;
  - each ib_valid word drives wr_en=1 and wr_data=ib_data;
  - after BURST_LEN accepted words, go to WR_CMD.
- WR_CMD:
  - hold cmd_en=1, instr=000, addr=wr_ptr for one cycle when !cmd_full; stall while cmd_full;
  - on issue, wr_ptr += BURST_LEN, occupancy += BURST_LEN, then go to IDLE.
- RD_CMD:
  - same command rule with instr=001, addr=rd_ptr;
  - on issue, rd_ptr += BURST_LEN, occupancy -= BURST_LEN, then go to RD_DRAIN.
- RD_DRAIN:
  - rd_en = !rd_empty;
  - each popped word is registered to ob_data with ob_we one cycle later;
  - after BURST_LEN pops, go to IDLE.

Boundary conditions:
- Deasserting writes_en or reads_en mid-burst does not abort; the current burst completes.
- Ring full (occupancy = RING_WORDS) blocks writes; ring empty blocks reads. No overflow or underflow is possible.
- reset in any state: return to IDLE next cycle; pointers, occupancy and counters go to 0. In-flight MCB FIFO contents are not drained, so reset is ORed with c3_rst0 and the pipe FIFO reset at top level.

## Timing
Reset values:
- ib_re, ob_we, cmd_en, wr_en and rd_en reset to 0.
- cmd_instr, cmd_bl, cmd_byte_addr, wr_data, ob_data, occupancy and the burst counters reset to 0.
- wr_mask is constant 0.

Latencies and throughput:
- Grant latency: one cycle from IDLE with W_OK/R_OK high to the first ib_re or cmd_en.
- ib_re → wr_en: one cycle.
- Minimum write burst: BURST_LEN+3 cycles from grant to return to IDLE.
- rd_en → ob_we: one cycle.
- Read burst: 2 cycles plus the drain time (depends on MCB latency).
- cmd_en is high for exactly one cycle per burst.
- occupancy updates on the cycle after cmd_en.

## Configuration
Macro: RING_DMA_STATS_EN.
- Defined: wr_bursts and rd_bursts count issued write/read commands. Each is a 32-bit saturating counter, cleared by reset.
- Undefined: both outputs are tied to 0 and no counter logic is built.

## Test plan
All scenarios use BURST_LEN=32 and RING_WORDS=256.
- Load 64 words (0..63) with only writes_en high → two write commands at byte addresses 0x000 and 0x080; occupancy ends at 64.
- Then raise reads_en with ob_count=0 → two read commands at 0x000 and 0x080; outbound receives 0..63 in order; occupancy ends at 0.
- Stream 512 words through with both enables high → bursts alternate W,R once both are eligible; addresses wrap from 0x380 to 0x000; data order is preserved.
- Fill the ring to 256 with reads_en=0 → no further write is issued even with ib_count=1000. Set ob_count=1000 with reads_en=1 → no read is issued.
- Hold cmd_full high for 5 cycles in WR_CMD → cmd_en is delayed 5 cycles and issued exactly once.
- Assert reset mid-WR_FILL after 10 words → all outputs are 0 next cycle and occupancy=0. With RING_DMA_STATS_EN defined, wr_bursts=3 after 3 write bursts.

Source files
------------

// File: rtl/ddr_ring_dma.sv
// DMA engine using a DDR2 region as a ring FIFO between the host pipe-in and pipe-out buffers.
// Optional RING_DMA_STATS_EN builds 32-bit saturating write/read burst counters.
module ddr_ring_dma #(
  parameter int DATA_W     = 32,
  parameter int BURST_LEN  = 32,
  parameter int ADDR_W     = 30,
  parameter int BASE_ADDR  = 0,
  parameter int RING_WORDS = 1024,
  parameter int CNT_W      = 10,
  parameter int OB_DEPTH   = 1023
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                calib_done,
  input  logic                                writes_en,
  input  logic                                reads_en,
  output logic                                ib_re,
  input  logic [DATA_W-1:0]                   ib_data,
  input  logic                                ib_valid,
  input  logic [CNT_W-1:0]                    ib_count,
  output logic                                ob_we,
  output logic [DATA_W-1:0]                   ob_data,
  input  logic [CNT_W-1:0]                    ob_count,
  output logic                                cmd_en,
  output logic [2:0]                          cmd_instr,
  output logic [5:0]                          cmd_bl,
  output logic [ADDR_W-1:0]                   cmd_byte_addr,
  input  logic                                cmd_full,
  output logic                                wr_en,
  output logic [DATA_W-1:0]                   wr_data,
  output logic [DATA_W/8-1:0]                 wr_mask,
  input  logic                                wr_full,
  output logic                                rd_en,
  input  logic [DATA_W-1:0]                   rd_data,
  input  logic                                rd_empty,
  output logic [$clog2(RING_WORDS+1)-1:0]     occupancy,
  output logic [31:0]                         wr_bursts,
  output logic [31:0]                         rd_bursts
);

  localparam int OCC_W = $clog2(RING_WORDS+1);
  localparam int PTR_W = (RING_WORDS > 1) ? $clog2(RING_WORDS) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_FILL  = 3'd1;
  localparam logic [2:0] S_WR_CMD   = 3'd2;
  localparam logic [2:0] S_RD_CMD   = 3'd3;
  localparam logic [2:0] S_RD_DRAIN = 3'd4;

  logic [2:0]       state;
  logic [6:0]       cnt_req;
  logic [6:0]       cnt_done;
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [OCC_W-1:0] occ;
  logic             last_wr;
  logic             w_ok, r_ok, grant_wr, grant_rd;

  assign occupancy = occ;
  assign wr_mask   = '0;

  always_comb begin
    w_ok = calib_done && writes_en && (ib_count >= CNT_W'(BURST_LEN))
           && (occ <= OCC_W'(RING_WORDS - BURST_LEN));
    r_ok = calib_done && reads_en && (occ >= OCC_W'(BURST_LEN))
           && (ob_count <= CNT_W'(OB_DEPTH - BURST_LEN - 1));
    // On a tie, serve the direction that did not win last time
    grant_wr = w_ok && (!r_ok || !last_wr);
    grant_rd = r_ok && !grant_wr;
  end

  always_comb begin
    wr_ptr_nxt = (wr_ptr == PTR_W'(RING_WORDS - BURST_LEN)) ? '0 : wr_ptr + PTR_W'(BURST_LEN);
    rd_ptr_nxt = (rd_ptr == PTR_W'(RING_WORDS - BURST_LEN)) ? '0 : rd_ptr + PTR_W'(BURST_LEN);
    wr_addr    = ADDR_W'(BASE_ADDR) + ADDR_W'(wr_ptr) * ADDR_W'(DATA_W/8);
    rd_addr    = ADDR_W'(BASE_ADDR) + ADDR_W'(rd_ptr) * ADDR_W'(DATA_W/8);
  end

  // Strobes decode directly from the registered state so the grant-to-strobe latency is one cycle
  always_comb begin
    ib_re         = (state == S_WR_FILL) && (cnt_req < 7'(BURST_LEN)) && !wr_full;
    wr_en         = (state == S_WR_FILL) && ib_valid;
    wr_data       = wr_en ? ib_data : '0;
    cmd_en        = ((state == S_WR_CMD) || (state == S_RD_CMD)) && !cmd_full;
    cmd_instr     = (state == S_RD_CMD) ? 3'b001 : 3'b000;
    cmd_bl        = ((state == S_WR_CMD) || (state == S_RD_CMD)) ? 6'(BURST_LEN - 1) : '0;
    cmd_byte_addr = (state == S_WR_CMD) ? wr_addr : (state == S_RD_CMD) ? rd_addr : '0;
    rd_en         = (state == S_RD_DRAIN) && !rd_empty;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt_req  <= '0;
      cnt_done <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      last_wr  <= 1'b0;
      ob_we    <= 1'b0;
      ob_data  <= '0;
    end else begin
      ob_we <= rd_en;
      if (rd_en) ob_data <= rd_data;
      case (state)
        S_IDLE: begin
          cnt_req  <= '0;
          cnt_done <= '0;
          if (grant_wr) begin
            state   <= S_WR_FILL;
            last_wr <= 1'b1;
          end else if (grant_rd) begin
            state   <= S_RD_CMD;
            last_wr <= 1'b0;
          end
        end
        S_WR_FILL: begin
          if (ib_re) cnt_req <= cnt_req + 7'd1;
          if (wr_en) begin
            if (cnt_done == 7'(BURST_LEN - 1)) state <= S_WR_CMD;
            else cnt_done <= cnt_done + 7'd1;
          end
        end
        S_WR_CMD: begin
          if (cmd_en) begin
            wr_ptr <= wr_ptr_nxt;
            occ    <= occ + OCC_W'(BURST_LEN);
            state  <= S_IDLE;
          end
        end
        S_RD_CMD: begin
          if (cmd_en) begin
            rd_ptr   <= rd_ptr_nxt;
            occ      <= occ - OCC_W'(BURST_LEN);
            cnt_done <= '0;
            state    <= S_RD_DRAIN;
          end
        end
        S_RD_DRAIN: begin
          if (rd_en) begin
            if (cnt_done == 7'(BURST_LEN - 1)) state <= S_IDLE;
            else cnt_done <= cnt_done + 7'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RING_DMA_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bursts <= '0;
      rd_bursts <= '0;
    end else begin
      if (cmd_en && (state == S_WR_CMD) && (wr_bursts != '1)) wr_bursts <= wr_bursts + 32'd1;
      if (cmd_en && (state == S_RD_CMD) && (rd_bursts != '1)) rd_bursts <= rd_bursts + 32'd1;
    end
  end
`else
  assign wr_bursts = '0;
  assign rd_bursts = '0;
`endif

endmodule

// File: tb/tb_ddr_ring_dma.sv
// Directed bench for ddr_ring_dma with behavioural pipe FIFOs and MCB port (BURST_LEN=32, RING_WORDS=256).
module tb_ddr_ring_dma;

  logic        clk = 1'b0;
  logic        reset, calib_done, writes_en, reads_en;
  logic        ib_re, ib_valid, ob_we, cmd_en, cmd_full, wr_en, wr_full, rd_en, rd_empty;
  logic [31:0] ib_data, ob_data, wr_data, rd_data, wr_bursts, rd_bursts;
  logic [9:0]  ib_count, ob_count;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic [3:0]  wr_mask;
  logic [8:0]  occupancy;

  logic        ib_ovr;
  int          in_mem [0:2047];
  int          in_head = 0, in_tail = 0;
  int          mem [0:255];
  int          wbuf [0:63];
  int          wn = 0;
  int          rq [0:1023];
  int          rq_head = 0, rq_tail = 0;
  int          out_mem [0:1023];
  int          out_n = 0;
  logic [2:0]  log_i [0:127];
  int          log_a [0:127];
  int          log_n = 0;
  int          wr_words = 0;
  int          n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  ddr_ring_dma #(
    .DATA_W(32), .BURST_LEN(32), .ADDR_W(30), .BASE_ADDR(0),
    .RING_WORDS(256), .CNT_W(10), .OB_DEPTH(1023)
  ) dut (
    .clk(clk), .reset(reset), .calib_done(calib_done), .writes_en(writes_en), .reads_en(reads_en),
    .ib_re(ib_re), .ib_data(ib_data), .ib_valid(ib_valid), .ib_count(ib_count),
    .ob_we(ob_we), .ob_data(ob_data), .ob_count(ob_count),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
    .cmd_full(cmd_full), .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask), .wr_full(wr_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
    .occupancy(occupancy), .wr_bursts(wr_bursts), .rd_bursts(rd_bursts)
  );

  assign ib_count = ib_ovr ? 10'd1000 : 10'(in_tail - in_head);
  assign rd_data  = rq[rq_head % 1024];
  assign rd_empty = (rq_head == rq_tail);

  // Pipe-in FIFO: data appears the cycle after ib_re
  always @(posedge clk) begin
    if (reset) begin
      ib_valid <= 1'b0;
      ib_data  <= '0;
      in_head  <= in_tail;
    end else if (ib_re && (in_head != in_tail)) begin
      ib_valid <= 1'b1;
      ib_data  <= in_mem[in_head % 2048];
      in_head  <= in_head + 1;
    end else begin
      ib_valid <= 1'b0;
    end
  end

  // MCB user port: write data buffered until the write command lands it in memory
  always @(posedge clk) begin
    if (reset) begin
      wn      <= 0;
      rq_head <= rq_tail;
    end else begin
      if (wr_en) begin
        wbuf[wn % 64] <= wr_data;
        wn <= wn + 1;
        wr_words <= wr_words + 1;
      end
      if (cmd_en) begin
        log_i[log_n % 128] <= cmd_instr;
        log_a[log_n % 128] <= int'(cmd_byte_addr);
        log_n <= log_n + 1;
        if (cmd_instr == 3'b000) begin
          for (int k = 0; k < 32; k++) mem[(int'(cmd_byte_addr >> 2) + k) % 256] <= wbuf[k];
          wn <= 0;
        end else begin
          for (int k = 0; k < 32; k++) rq[(rq_tail + k) % 1024] <= mem[(int'(cmd_byte_addr >> 2) + k) % 256];
          rq_tail <= rq_tail + 32;
        end
      end
      if (rd_en) rq_head <= rq_head + 1;
      if (ob_we) begin
        out_mem[out_n % 1024] <= ob_data;
        out_n <= out_n + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_words(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      in_mem[in_tail % 2048] = base + i;
      in_tail = in_tail + 1;
    end
  endtask

  initial begin
    int log0, out0, ww0, head0, errs, pulses;
    logic [2:0] ei;
    int ea;
    reset = 1'b1; calib_done = 1'b1; writes_en = 1'b0; reads_en = 1'b0;
    cmd_full = 1'b0; wr_full = 1'b0; ob_count = '0; ib_ovr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ib_re", ib_re, 0);
    check("rst_cmd_en", cmd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_ob_we", ob_we, 0);
    check("rst_occ", occupancy, 0);
    check("rst_addr", cmd_byte_addr, 0);
    check("rst_bl", cmd_bl, 0);
    check("rst_mask", wr_mask, 0);
    check("rst_wr_bursts", wr_bursts, 0);
    reset = 1'b0;

    // Two write bursts of 0..63
    log0 = log_n;
    push_words(0, 64);
    writes_en = 1'b1;
    for (int i = 0; i < 400 && occupancy != 9'd64; i++) @(negedge clk);
    check("w2_occ", occupancy, 64);
    check("w2_ncmd", log_n - log0, 2);
    check("w2_instr0", log_i[log0 % 128], 3'b000);
    check("w2_addr0", log_a[log0 % 128], 32'h000);
    check("w2_addr1", log_a[(log0 + 1) % 128], 32'h080);
    writes_en = 1'b0;

    // Drain both bursts back out
    log0 = log_n; out0 = out_n;
    reads_en = 1'b1;
    for (int i = 0; i < 400 && !((out_n - out0 == 64) && occupancy == 9'd0); i++) @(negedge clk);
    check("r2_nout", out_n - out0, 64);
    check("r2_occ", occupancy, 0);
    check("r2_ncmd", log_n - log0, 2);
    check("r2_instr0", log_i[log0 % 128], 3'b001);
    check("r2_addr0", log_a[log0 % 128], 32'h000);
    check("r2_addr1", log_a[(log0 + 1) % 128], 32'h080);
    errs = 0;
    for (int i = 0; i < 64; i++) if (out_mem[(out0 + i) % 1024] != i) errs++;
    check("r2_data_errs", errs, 0);
    check("r2_last_word", out_mem[(out0 + 63) % 1024], 63);
    reads_en = 1'b0;

    // Stream 512 words with both enables: W,R alternate from wr_ptr=rd_ptr=64 and wrap past 0x380
    log0 = log_n; out0 = out_n;
    push_words(1000, 512);
    writes_en = 1'b1; reads_en = 1'b1;
    for (int i = 0; i < 5000 && !((out_n - out0 == 512) && occupancy == 9'd0); i++) @(negedge clk);
    check("s_nout", out_n - out0, 512);
    check("s_ncmd", log_n - log0, 32);
    errs = 0;
    for (int i = 0; i < 32; i++) begin
      ei = (i % 2 == 0) ? 3'b000 : 3'b001;
      ea = (32'h100 + 32'h80 * (i / 2)) % 32'h400;
      if (log_i[(log0 + i) % 128] != ei || log_a[(log0 + i) % 128] != ea) errs++;
    end
    check("s_cmd_seq_errs", errs, 0);
    check("s_wr_addr_380", log_a[(log0 + 10) % 128], 32'h380);
    check("s_wr_addr_wrap", log_a[(log0 + 12) % 128], 32'h000);
    check("s_rd_addr_wrap", log_a[(log0 + 13) % 128], 32'h000);
    errs = 0;
    for (int i = 0; i < 512; i++) if (out_mem[(out0 + i) % 1024] != 1000 + i) errs++;
    check("s_data_errs", errs, 0);
    writes_en = 1'b0; reads_en = 1'b0;

    // cmd_full held for 5 cycles in WR_CMD
    log0 = log_n; ww0 = wr_words;
    cmd_full = 1'b1;
    push_words(5000, 32);
    writes_en = 1'b1;
    for (int i = 0; i < 200 && (wr_words - ww0) != 32; i++) @(negedge clk);
    check("cf_fill_words", wr_words - ww0, 32);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      pulses += int'(cmd_en);
      @(negedge clk);
    end
    check("cf_stall_pulses", pulses, 0);
    cmd_full = 1'b0;
    #1;
    check("cf_issue_now", cmd_en, 1);
    for (int i = 0; i < 10; i++) begin
      pulses += int'(cmd_en);
      @(negedge clk);
    end
    check("cf_total_pulses", pulses, 1);
    check("cf_addr", log_a[log0 % 128], 32'h100);
    check("cf_occ", occupancy, 32);
    writes_en = 1'b0;

    // Fill ring to 256; full ring blocks writes, high ob_count blocks reads
    log0 = log_n;
    push_words(7000, 300);
    writes_en = 1'b1;
    for (int i = 0; i < 2000 && occupancy != 9'd256; i++) @(negedge clk);
    check("f_occ_full", occupancy, 256);
    check("f_ncmd", log_n - log0, 7);
    ib_ovr = 1'b1;
    head0 = in_head;
    repeat (100) @(negedge clk);
    check("f_no_write", log_n - log0, 7);
    check("f_no_ib_re", in_head - head0, 0);
    ob_count = 10'd1000; reads_en = 1'b1;
    repeat (100) @(negedge clk);
    check("f_no_read", log_n - log0, 7);
    check("f_occ_hold", occupancy, 256);
    reads_en = 1'b0; writes_en = 1'b0; ob_count = '0; ib_ovr = 1'b0;

    // Reset mid-WR_FILL after 10 words
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("r_occ_cleared", occupancy, 0);
    ww0 = wr_words;
    push_words(9000, 40);
    writes_en = 1'b1;
    for (int i = 0; i < 100 && (wr_words - ww0) != 10; i++) @(negedge clk);
    check("r_words_before", wr_words - ww0, 10);
    reset = 1'b1; writes_en = 1'b0;
    @(negedge clk);
    check("r_ib_re", ib_re, 0);
    check("r_wr_en", wr_en, 0);
    check("r_wr_data", wr_data, 0);
    check("r_cmd_en", cmd_en, 0);
    check("r_ob_we", ob_we, 0);
    check("r_ob_data", ob_data, 0);
    check("r_occ", occupancy, 0);
    reset = 1'b0;
    @(negedge clk);

    // Three write bursts for the burst counters
    push_words(11000, 96);
    writes_en = 1'b1;
    for (int i = 0; i < 600 && occupancy != 9'd96; i++) @(negedge clk);
    check("st_occ", occupancy, 96);
`ifdef RING_DMA_STATS_EN
    check("st_wr_bursts", wr_bursts, 3);
`else
    check("st_wr_bursts", wr_bursts, 0);
`endif
    check("st_rd_bursts", rd_bursts, 0);
    writes_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
